// File: rtl/ltpi_pkg.sv
// rtl/ltpi_pkg.sv - shared LTPI constants, scheduler state type and CRC-8 byte step.
package ltpi_pkg;

    localparam logic [7:0] LTPI_CRC8_POLY   = 8'h07;
    localparam logic [7:0] LTPI_COMMA_K28_5 = 8'hBC;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ltpi_sched_state_t;

    // One byte of an MSB-first CRC-8 over LTPI_CRC8_POLY.
    function automatic logic [7:0] ltpi_crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ LTPI_CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/ltpi_crc8_bytes.sv
// rtl/ltpi_crc8_bytes.sv - combinational CRC-8 (init 0, no final xor) over NBYTES bytes, byte 0 first.
module ltpi_crc8_bytes
    import ltpi_pkg::*;
#(
    parameter int NBYTES = 15
) (
    input  logic [NBYTES*8-1:0] i_data,
    output logic [7:0]          o_crc
);

    always_comb begin
        o_crc = '0;
        for (int i = 0; i < NBYTES; i++) begin
            o_crc = ltpi_crc8_step(o_crc, i_data[8*i +: 8]);
        end
    end

endmodule

// File: rtl/ltpi_frame_tx_sched.sv
// rtl/ltpi_frame_tx_sched.sv - snapshots an LTPI frame, appends CRC-8 and emits LANES-byte beats at a programmable period.
module ltpi_frame_tx_sched
    import ltpi_pkg::*;
#(
    parameter int  FRAME_BYTES = 16,
    parameter int  LANES       = 1,
    parameter int  CNT_W       = 6,
    localparam int BEATS       = FRAME_BYTES / LANES,
    localparam int OFF_W       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic [CNT_W-1:0]             i_period_max,
    input  logic [(FRAME_BYTES-1)*8-1:0] i_frame_in,
    output logic                         o_frame_ack,
    output logic                         o_sym_valid,
    output logic [LANES*8-1:0]           o_sym_data,
    output logic [LANES-1:0]             o_sym_k,
    output logic [OFF_W-1:0]             o_sym_offset,
    output logic                         o_frame_start
);

    ltpi_sched_state_t r_state;
    ltpi_sched_state_t w_state_nxt;

    logic [(FRAME_BYTES-1)*8-1:0] r_snap;
    logic [CNT_W-1:0]             r_period;
    logic [CNT_W-1:0]             r_cnt;
    logic [OFF_W-1:0]             r_beat;
    logic                         r_valid;
    logic                         r_ack;
    logic                         r_loaded;

    logic                         w_tick;
    logic                         w_last;
    logic                         w_capture;
    logic                         w_advance;
    logic [7:0]                   w_crc;
    logic [FRAME_BYTES*8-1:0]     w_frame;
    logic [LANES*8-1:0]           w_data;
    logic [LANES-1:0]             w_k;

    assign w_tick = (r_state == RUN) && (r_cnt == r_period - CNT_W'(1));
    assign w_last = (r_beat == OFF_W'(BEATS - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_enable) begin
                    w_state_nxt = RUN;
                    w_capture   = 1'b1;
                end
            end
            RUN: begin
                if (w_tick) begin
                    if (!w_last) begin
                        w_advance = 1'b1;
                    end else if (i_enable) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The beat counter and snapshot only move on a strobe, so the beat outputs
    // can be decoded from them and still hold steady between strobes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_snap   <= '0;
            r_period <= '0;
            r_cnt    <= '0;
            r_beat   <= '0;
            r_valid  <= 1'b0;
            r_ack    <= 1'b0;
            r_loaded <= 1'b0;
        end else begin
            r_ack   <= w_capture;
            r_valid <= w_capture | w_advance;
            if (w_capture) begin
                r_snap   <= i_frame_in;
                r_period <= (i_period_max == '0) ? CNT_W'(1) : i_period_max;
                r_beat   <= '0;
                r_cnt    <= '0;
                r_loaded <= 1'b1;
            end else begin
                if (w_advance) begin
                    r_beat <= r_beat + OFF_W'(1);
                end
                if (w_tick) begin
                    r_cnt <= '0;
                end else if (r_state == RUN) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    ltpi_crc8_bytes #(
        .NBYTES (FRAME_BYTES - 1)
    ) u_crc (
        .i_data (r_snap),
        .o_crc  (w_crc)
    );

    assign w_frame = {w_crc, r_snap};

    always_comb begin
        w_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (r_beat == OFF_W'(b)) begin
                w_data = w_frame[b*LANES*8 +: LANES*8];
            end
        end
    end

    // r_loaded keeps the K flag low on the idle beat-0 value seen after reset.
    always_comb begin
        w_k    = '0;
        w_k[0] = r_loaded && (r_beat == '0);
    end

    assign o_frame_ack   = r_ack;
    assign o_sym_valid   = r_valid;
    assign o_sym_data    = w_data;
    assign o_sym_k       = w_k;
    assign o_sym_offset  = r_beat;
    assign o_frame_start = r_valid && (r_beat == '0);

endmodule

// File: tb/tb_ltpi_frame_tx_sched.sv
// tb/tb_ltpi_frame_tx_sched.sv - scoreboard bench for ltpi_frame_tx_sched over three parameter sets.
module tb_ltpi_frame_tx_sched;
    import ltpi_pkg::*;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [1:0]  k;
        logic [3:0]  off;
        logic        start;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // a: 10 bytes x1 lane, b: 16 bytes x2 lanes, c: 16 bytes x1 lane
    logic         a_en, a_ack, a_val, a_st;
    logic [5:0]   a_per;
    logic [71:0]  a_frm;
    logic [7:0]   a_dat;
    logic [0:0]   a_k;
    logic [3:0]   a_off;

    logic         b_en, b_ack, b_val, b_st;
    logic [5:0]   b_per;
    logic [119:0] b_frm;
    logic [15:0]  b_dat;
    logic [1:0]   b_k;
    logic [2:0]   b_off;

    logic         c_en, c_ack, c_val, c_st;
    logic [5:0]   c_per;
    logic [119:0] c_frm;
    logic [7:0]   c_dat;
    logic [0:0]   c_k;
    logic [3:0]   c_off;

    ltpi_frame_tx_sched #(.FRAME_BYTES(10), .LANES(1), .CNT_W(6)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_enable(a_en), .i_period_max(a_per), .i_frame_in(a_frm),
        .o_frame_ack(a_ack), .o_sym_valid(a_val), .o_sym_data(a_dat), .o_sym_k(a_k),
        .o_sym_offset(a_off), .o_frame_start(a_st)
    );

    ltpi_frame_tx_sched #(.FRAME_BYTES(16), .LANES(2), .CNT_W(6)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_enable(b_en), .i_period_max(b_per), .i_frame_in(b_frm),
        .o_frame_ack(b_ack), .o_sym_valid(b_val), .o_sym_data(b_dat), .o_sym_k(b_k),
        .o_sym_offset(b_off), .o_frame_start(b_st)
    );

    ltpi_frame_tx_sched #(.FRAME_BYTES(16), .LANES(1), .CNT_W(6)) dut_c (
        .i_clk(clk), .i_reset(rst), .i_enable(c_en), .i_period_max(c_per), .i_frame_in(c_frm),
        .o_frame_ack(c_ack), .o_sym_valid(c_val), .o_sym_data(c_dat), .o_sym_k(c_k),
        .o_sym_offset(c_off), .o_frame_start(c_st)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t qa[$], qb[$], qc[$];
    int   aqa[$], aqb[$], aqc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit-serial reference CRC: shift each message bit in MSB-first.
    function automatic logic [7:0] m_crc(input logic [7:0] fb[16], input int n);
        logic [7:0] c;
        logic       fbk;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int j = 7; j >= 0; j--) begin
                fbk = c[7] ^ fb[i][j];
                c   = {c[6:0], 1'b0} ^ (fbk ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    function automatic logic [119:0] pack(input logic [7:0] fb[16], input int n);
        logic [119:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = fb[i];
        return r;
    endfunction

    task automatic rand_fb(output logic [7:0] fb[16]);
        for (int i = 0; i < 16; i++) fb[i] = 8'($urandom_range(0, 255));
        fb[0] = LTPI_COMMA_K28_5;
    endtask

    task automatic push_frame(input int inst, input logic [7:0] fb_in[16], input int nb, input int lanes,
                              input int p, input int s0, input int nbeats, input int crc_const);
        logic [7:0] fb[16];
        exp_t       e;
        fb = fb_in;
        fb[nb-1] = (crc_const < 0) ? m_crc(fb, nb - 1) : crc_const[7:0];
        for (int b = 0; b < nbeats; b++) begin
            e.cyc  = s0 + b * p;
            e.data = '0;
            for (int j = 0; j < lanes; j++) e.data[j*8 +: 8] = fb[b*lanes + j];
            e.k     = (b == 0) ? 2'b01 : 2'b00;
            e.off   = 4'(b);
            e.start = (b == 0);
            case (inst)
                0:       qa.push_back(e);
                1:       qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end
        case (inst)
            0:       aqa.push_back(s0);
            1:       aqb.push_back(s0);
            default: aqc.push_back(s0);
        endcase
    endtask

    task automatic check_beat(input string nm, input exp_t e, input logic [15:0] d, input logic [1:0] k,
                              input logic [3:0] off, input logic st);
        chk($sformatf("%s_b%0d_cycle", nm, e.off), cyc, e.cyc);
        chk($sformatf("%s_b%0d_data", nm, e.off), {16'h0, d}, {16'h0, e.data});
        chk($sformatf("%s_b%0d_k", nm, e.off), {30'h0, k}, {30'h0, e.k});
        chk($sformatf("%s_b%0d_offset", nm, e.off), {28'h0, off}, {28'h0, e.off});
        chk($sformatf("%s_b%0d_frame_start", nm, e.off), {31'h0, st}, {31'h0, e.start});
    endtask

    always @(negedge clk) begin
        if (a_val) begin
            chk("a_strobe_expected", {31'h0, qa.size() > 0}, 1);
            if (qa.size() > 0) check_beat("a", qa.pop_front(), {8'h0, a_dat}, {1'b0, a_k}, a_off, a_st);
        end
        if (a_ack) begin
            chk("a_ack_expected", {31'h0, aqa.size() > 0}, 1);
            if (aqa.size() > 0) chk("a_ack_cycle", cyc, aqa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (b_val) begin
            chk("b_strobe_expected", {31'h0, qb.size() > 0}, 1);
            if (qb.size() > 0) check_beat("b", qb.pop_front(), b_dat, b_k, {1'b0, b_off}, b_st);
        end
        if (b_ack) begin
            chk("b_ack_expected", {31'h0, aqb.size() > 0}, 1);
            if (aqb.size() > 0) chk("b_ack_cycle", cyc, aqb.pop_front());
        end
    end

    always @(negedge clk) begin
        if (c_val) begin
            chk("c_strobe_expected", {31'h0, qc.size() > 0}, 1);
            if (qc.size() > 0) check_beat("c", qc.pop_front(), {8'h0, c_dat}, {1'b0, c_k}, c_off, c_st);
        end
        if (c_ack) begin
            chk("c_ack_expected", {31'h0, aqc.size() > 0}, 1);
            if (aqc.size() > 0) chk("c_ack_cycle", cyc, aqc.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_outputs"}, {16'h0, a_val, a_dat, a_k, a_off, a_ack, a_st}, 0);
        chk({tag, "_b_outputs"}, {8'h0, b_val, b_dat, b_k, b_off, b_ack, b_st}, 0);
        chk({tag, "_c_outputs"}, {16'h0, c_val, c_dat, c_k, c_off, c_ack, c_st}, 0);
    endtask

    initial begin
        logic [7:0]   fb[16];
        logic [7:0]   fb2[16];
        logic [119:0] tmp;
        int           s0;

        rst   = 1'b1;
        a_en  = 1'b0; a_per = '0; a_frm = '0;
        b_en  = 1'b0; b_per = '0; b_frm = '0;
        c_en  = 1'b0; c_per = '0; c_frm = '0;
        for (int i = 0; i < 16; i++) begin
            fb[i]  = 8'h00;
            fb2[i] = 8'h00;
        end
        #2;
        check_all_zero("reset");
        repeat (2) step();
        rst = 1'b0;
        step();
        check_all_zero("after_release");

        // standard CRC check vector "123456789" -> 0xF4, period 3
        for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
        tmp   = pack(fb, 9);
        a_frm = tmp[71:0];
        a_per = 6'd3;
        a_en  = 1'b1;
        push_frame(0, fb, 10, 1, 3, cyc + 1, 10, 'hF4);
        step();
        a_en = 1'b0;
        repeat (35) step();

        // two-lane striping, period 0 treated as 1
        for (int i = 0; i < 15; i++) fb[i] = 8'h10 + 8'(i);
        b_frm = pack(fb, 15);
        b_per = 6'd0;
        b_en  = 1'b1;
        push_frame(1, fb, 16, 2, 1, cyc + 1, 8, -1);
        step();
        b_en = 1'b0;
        repeat (12) step();

        // snapshot coherence: frame_in churns every cycle after capture
        rand_fb(fb);
        c_frm = pack(fb, 15);
        c_per = 6'd2;
        c_en  = 1'b1;
        push_frame(2, fb, 16, 1, 2, cyc + 1, 16, -1);
        for (int c = 0; c < 40; c++) begin
            step();
            c_en = 1'b0;
            tmp  = {$urandom(), $urandom(), $urandom(), $urandom()};
            c_frm = tmp;
        end

        // three back-to-back frames at period 2 with churning input
        rand_fb(fb);
        c_frm = pack(fb, 15);
        c_per = 6'd2;
        c_en  = 1'b1;
        s0    = cyc + 1;
        push_frame(2, fb, 16, 1, 2, s0, 16, -1);
        for (int c = 0; c < 102; c++) begin
            step();
            rand_fb(fb2);
            c_frm = pack(fb2, 15);
            if (cyc == s0 + 31 || cyc == s0 + 63) push_frame(2, fb2, 16, 1, 2, cyc + 1, 16, -1);
            if (cyc == s0 + 64) c_en = 1'b0;
        end

        // period change 4->2 mid-frame, then enable drop at beat 3 of the next frame
        for (int i = 0; i < 15; i++) fb[i] = 8'h40 + 8'(i);
        for (int i = 0; i < 15; i++) fb2[i] = 8'h80 + 8'(3 * i);
        c_frm = pack(fb, 15);
        c_per = 6'd4;
        c_en  = 1'b1;
        s0    = cyc + 1;
        push_frame(2, fb, 16, 1, 4, s0, 16, -1);
        for (int c = 0; c < 106; c++) begin
            step();
            if (cyc == s0 + 20) c_per = 6'd2;
            if (cyc == s0 + 10) c_frm = pack(fb2, 15);
            if (cyc == s0 + 63) push_frame(2, fb2, 16, 1, 2, s0 + 64, 16, -1);
            if (cyc == s0 + 70) c_en = 1'b0;
        end

        // asynchronous reset between edges just after beat 7
        rand_fb(fb);
        c_frm = pack(fb, 15);
        c_per = 6'd3;
        c_en  = 1'b1;
        s0    = cyc + 1;
        push_frame(2, fb, 16, 1, 3, s0, 8, -1);
        for (int c = 0; c < 40 && cyc < s0 + 21; c++) step();
        chk("reset_point_cycle", cyc, s0 + 21);
        #6;
        rst = 1'b1;
        #1;
        check_all_zero("mid_frame_reset");
        chk("c_beats_before_reset", qc.size(), 0);
        step();
        rst = 1'b0;
        push_frame(2, fb, 16, 1, 3, cyc + 1, 16, -1);
        step();
        c_en = 1'b0;
        repeat (55) step();

        chk("a_pending_beats", qa.size(), 0);
        chk("b_pending_beats", qb.size(), 0);
        chk("c_pending_beats", qc.size(), 0);
        chk("a_pending_acks", aqa.size(), 0);
        chk("b_pending_acks", aqb.size(), 0);
        chk("c_pending_acks", aqc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ltpi_frame_tx_sched.md
# ltpi_frame_tx_sched

Parametrised LTPI transmit frame scheduler. It snapshots a complete LTPI frame in one cycle and appends a CRC-8. It emits the frame as symbol beats, `LANES` bytes wide, at a programmable symbol period. It sits between the LTPI frame builder and the per-lane 8b/10b encoders plus the LVDS PHY, and replaces the fixed 16-byte, single-lane offset scheduler used in the first-generation Tx path.

## Interface
- `FRAME_BYTES`, 16: total frame bytes including comma and CRC; must be a multiple of `LANES` and at least 4.
- `LANES`, 1: bytes per beat; allowed values 1, 2 or 4.
- `CNT_W`, 6: width of the symbol-period counter.
- `BEATS`, derived: `FRAME_BYTES/LANES`.
- `OFF_W`, derived: `max(1, $clog2(BEATS))`.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request, sampled only at frame boundaries.
- `period_max`  in  CNT_W  symbol period in clk cycles; a value of 0 is treated as 1.
- `frame_in`  in  (FRAME_BYTES-1)*8  byte i occupies bits [8i+7:8i]; byte 0 is the comma, bytes 1..FRAME_BYTES-2 are subtype and payload.
- `frame_ack`  out  1  one-cycle pulse, asserted the cycle after `frame_in` was captured.
- `sym_valid`  out  1  one-cycle strobe marking a beat.
- `sym_data`  out  LANES*8  beat bytes; lane j holds frame byte `beat*LANES+j`.
- `sym_k`  out  LANES  K-character flag per lane.
- `sym_offset`  out  OFF_W  beat index within the frame.
- `frame_start`  out  1  equals `sym_valid` and `sym_offset==0`.

## Operation
- **States:** IDLE and RUN.
- **Reset (async):** state=IDLE, all counters 0. Every output is 0: `sym_valid`, `sym_data`, `sym_k`, `sym_offset`, `frame_ack`, `frame_start`.
- **IDLE → RUN:** taken when `enable`=1. In the same cycle the block captures `frame_in` and `period_eff = max(period_max,1)`, sets beat=0 and starts the period counter at 0.
- **Period counter:** counts 0..period_eff-1 and generates `tick` at period_eff-1, then wraps to 0. With period_eff=1, `tick` is asserted every cycle.
- **Beat emission:** each beat, including beat 0 immediately after capture, is presented once, then beat increments on `tick`.
- **Last beat (beat=BEATS-1) on `tick`:**
  - If `enable`=1: recapture `frame_in` and `period_max`, set beat=0, and pulse `frame_ack`. There is no gap cycle between frames.
  - Otherwise: go to IDLE.
- **Mid-frame changes:** deasserting `enable` mid-frame never truncates the frame. Changes to `period_max` mid-frame are ignored until the next capture.
- **K flag:** `sym_k[0]`=1 only on beat 0; all other lanes and beats are 0.
- **CRC:**
  - CRC-8, polynomial 0x07, init 0x00, MSB-first, no final XOR.
  - Covers snapshot bytes 0..FRAME_BYTES-2 in frame order, comma included.
  - Computed combinationally from the snapshot register, so it is ready before the last beat.
  - Placed in lane LANES-1 of beat BEATS-1.
- **Coherence:** `frame_in` may change on any cycle. Only the captured snapshot is transmitted; a frame is never mixed across two captures.

## Timing
- **Capture to first beat:** capture at cycle t → `frame_ack`=1 at t+1; `sym_valid`=1 at t+1 with beat 0.
- **Beat to beat:** a `tick` at cycle c → the next beat's `sym_valid` at c+1, and `sym_valid` is otherwise 0.
- **Beat spacing:** exactly period_eff cycles. Frame period is `BEATS*period_eff` cycles while `enable` stays high.
- **Output hold:** `sym_data`, `sym_k` and `sym_offset` hold their values between strobes and change only with `sym_valid`.
- **Reset mid-frame:** outputs clear immediately (asynchronously). After release the block is in IDLE and the first capture occurs on the first cycle with `enable`=1.

## Structure
- **Additions to `ltpi_pkg`:**
  - `LTPI_CRC8_POLY` = 8'h07
  - `LTPI_COMMA_K28_5` = 8'hBC
  - a `ltpi_sched_state_t` enum {IDLE, RUN}
- **Sub-module `ltpi_crc8_bytes`:** a combinational, parametrised N-byte CRC-8 (parameter NBYTES), instantiated once over the snapshot.
- **Top level:** holds the snapshot register, the period counter, the beat counter, the FSM and the output registers.

## Test plan
- **Standard CRC check:** `FRAME_BYTES`=10, `LANES`=1, `period_max`=3, `frame_in`="123456789" (byte 0=0x31) → 10 strobes, 3 cycles apart; `sym_k`=1 only on the first; last byte 0xF4.
- **Two-lane striping:** `LANES`=2, `FRAME_BYTES`=16, bytes i=0x10+i (i=0..14), `period_max`=0 → 8 consecutive strobes. Beat 0 is {0x11,0x10} with `sym_k`=2'b01. Beat 7 lane 0=0x1E; lane 1=CRC of bytes 0x10..0x1E.
- **Snapshot coherence:** change `frame_in` every cycle during a frame → the transmitted bytes equal the value captured at the `frame_ack`-1 cycle, and the CRC matches those bytes.
- **Enable drop and period change mid-frame:** drop `enable` at beat 3 → beats 4..15 still sent, then IDLE with no further strobes. Change `period_max` 4→2 mid-frame → spacing stays 4 until the next frame, then becomes 2.
- **Back-to-back frames:** hold `enable` high for 3 frames (`period_max`=2, 16 beats) → `frame_ack` pulses exactly 32 cycles apart and beat 0 follows beat 15 after 2 cycles.
- **Async reset mid-frame:** assert `reset` at beat 7 between clock edges → all outputs are 0 immediately. After release with `enable`=1 the next strobe has `sym_offset`=0 and `sym_k[0]`=1.
